led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer_pkg.sv | 12 +
 rtl/led_sequencer_dwell_timer.sv | 39 +++
 rtl/led_sequencer.sv | 146 ++++++++++++++
 tb/tb_led_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared types for the LED sequencer.
// Holds the state enum and its encodings.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/led_sequencer_dwell_timer.sv
// Dwell timer: counts cycles while clear is low and flags the last cycle.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     holds the counter at zero
//   expired   high during the DWELL_CYCLES-th counted cycle
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int unsigned TW = (DWELL_CYCLES < 2) ? 1 : $clog2(DWELL_CYCLES);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = !clear && (cnt_q == TW'(DWELL_CYCLES - 1));

  // Next count: restart on clear or on the final cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer: buffers bytes while idle, then on start replays them to an
// LED latch, one load pulse per byte followed by a dwell period.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   wr_en/wr_data  buffer one byte per cycle while idle and not full
//   start, abort   begin a pass / return to idle (abort wins)
//   led_enabled    single-cycle load pulse; byte_out valid with it
//   busy, full, done  status; done pulses once when a pass completes
// Build option: LED_SEQUENCER_LOOP_EN makes the pass repeat until abort.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       abort,
  output logic       led_enabled,
  output logic [7:0] byte_out,
  output logic       busy,
  output logic       full,
  output logic       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          led_enabled_q, led_enabled_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          busy_q, busy_d;
  logic          full_q, full_d;
  logic          done_q, done_d;
  logic          wr_fire;
  logic          expired;
  logic [7:0]    mem_q [DEPTH];

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ST_DWELL),
    .expired(expired)
  );

  // Next state, pointers and registered outputs (derived from the next state).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_fire  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_en && (count_q < CW'(DEPTH))) begin
          wr_fire  = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end
        if (start && !abort && (count_q != '0)) begin
          state_d  = ST_SHOW;
          rd_ptr_d = '0;
        end
      end
      ST_SHOW: begin
        state_d = abort ? ST_IDLE : ST_DWELL;
      end
      ST_DWELL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          if ((CW'(rd_ptr_q) + CW'(1)) < count_q) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = ST_SHOW;
          end else begin
`ifdef LED_SEQUENCER_LOOP_EN
            rd_ptr_d = '0;
            state_d  = ST_SHOW;
`else
            state_d  = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        count_d  = '0;
        wr_ptr_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    led_enabled_d = (state_d == ST_SHOW);
    byte_out_d    = (state_d == ST_SHOW) ? mem_q[rd_ptr_d] : byte_out_q;
    busy_d        = (state_d != ST_IDLE);
    full_d        = (count_d == CW'(DEPTH));
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      led_enabled_q <= 1'b0;
      byte_out_q    <= '0;
      busy_q        <= 1'b0;
      full_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      led_enabled_q <= led_enabled_d;
      byte_out_q    <= byte_out_d;
      busy_q        <= busy_d;
      full_q        <= full_d;
      done_q        <= done_d;
    end
  end

  // Buffer storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign led_enabled = led_enabled_q;
  assign byte_out    = byte_out_q;
  assign busy        = busy_q;
  assign full        = full_q;
  assign done        = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer (DEPTH=8, DWELL_CYCLES=4).
// Expected load pulses and done pulses are queued with their cycle stamps;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_led_sequencer;

  typedef struct {
    int         cyc;
    logic       is_done;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       led_enabled;
  logic [7:0] byte_out;
  logic       busy;
  logic       full;
  logic       done;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  led_sequencer #(
    .DEPTH(8),
    .DWELL_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .abort(abort), .led_enabled(led_enabled),
    .byte_out(byte_out), .busy(busy), .full(full), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_pulse(input int c, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.is_done = 1'b0; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.cyc = c; e.is_done = 1'b1; e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (!rst && (led_enabled || done)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: led=%0b done=%0b byte=0x%0h at cycle %0d, required none",
                 led_enabled, done, byte_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.is_done != done || e.is_done == led_enabled ||
            (!e.is_done && e.data != byte_out)) begin
          n_bad++;
          $display("FAIL pulse: got led=%0b done=%0b byte=0x%0h cycle %0d, required done=%0b byte=0x%0h cycle %0d",
                   led_enabled, done, byte_out, cyc, e.is_done, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Writes bytes on consecutive cycles; returns at the negedge after the last.
  task automatic write_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = bs[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulses start for one cycle; c is the negedge cycle at which it was set.
  task automatic do_start(output int c);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},  int'(led_enabled), 0);
    check({tag, "_byte"}, int'(byte_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int c;
    tick(3);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Start with an empty buffer does nothing.
    do_start(c);
    check("empty_start_busy", int'(busy), 0);
    tick(3);
    check("empty_start_busy_later", int'(busy), 0);

`ifndef LED_SEQUENCER_LOOP_EN
    // Three-byte pass: pulses at +1, +6, +11, done at +16.
    write_bytes(8'h05, 8'h12, 8'hA0, 3);
    check("three_full", int'(full), 0);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    push_pulse(c + 1, 8'h05); push_pulse(c + 6, 8'h12);
    push_pulse(c + 11, 8'hA0); push_done(c + 16);
    @(negedge clk);
    start = 1'b0;
    check("pass_busy", int'(busy), 1);
    wait_until(c + 17);
    check("pass_end_busy", int'(busy), 0);
    check("pass_end_byte_hold", int'(byte_out), 8'hA0);
    // Buffer is empty after done, so a restart is ignored.
    do_start(c);
    tick(2);
    check("after_done_busy", int'(busy), 0);

    // Abort during the second dwell, then replay from the first byte.
    write_bytes(8'h05, 8'h12, 8'hA0, 3);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    push_pulse(c + 1, 8'h05); push_pulse(c + 6, 8'h12);
    @(negedge clk);
    start = 1'b0;
    wait_until(c + 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    tick(15);
    check("abort_idle_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    push_pulse(c + 1, 8'h05); push_pulse(c + 6, 8'h12);
    push_pulse(c + 11, 8'hA0); push_done(c + 16);
    @(negedge clk);
    start = 1'b0;
    wait_until(c + 18);

    // Nine writes into an 8-deep buffer: ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 7) check("full_after_7", int'(full), 0);
      if (i == 8) check("full_after_8", int'(full), 1);
      wr_en = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("full_after_9", int'(full), 1);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    for (int i = 0; i < 8; i++) push_pulse(c + 1 + 5 * i, 8'(i));
    push_done(c + 41);
    @(negedge clk);
    start = 1'b0;
    wait_until(c + 42);
    check("full_cleared", int'(full), 0);

    // Start together with abort in idle: abort wins.
    write_bytes(8'h3C, 8'h00, 8'h00, 1);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    push_pulse(c + 1, 8'h3C); push_done(c + 6);
    @(negedge clk);
    start = 1'b0;
    wait_until(c + 8);
`else
    // Looping pass over two bytes, period DWELL_CYCLES+1, no done.
    write_bytes(8'h11, 8'h22, 8'h00, 2);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    push_pulse(c + 1, 8'h11); push_pulse(c + 6, 8'h22);
    push_pulse(c + 11, 8'h11); push_pulse(c + 16, 8'h22);
    push_pulse(c + 21, 8'h11);
    @(negedge clk);
    start = 1'b0;
    wait_until(c + 23);
    check("loop_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("loop_abort_busy", int'(busy), 0);
    tick(12);
    // Abort retains the buffer: consume it with a short looped pass.
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    push_pulse(c + 1, 8'h11);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tick(3);
    // Reset empties the count so the next write sequence starts fresh.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    // Asynchronous reset in the middle of a dwell.
    write_bytes(8'h77, 8'h88, 8'h00, 2);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    push_pulse(c + 1, 8'h77);
    @(negedge clk);
    start = 1'b0;
    wait_until(c + 3);
    check("pre_reset_byte", int'(byte_out), 8'h77);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    tick(15);
    check("post_reset_busy", int'(busy), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
